// File: rtl/apb_ram_pkg.sv
// Shared parameters for the APB3 register-file RAM.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package apb_ram_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 32;

    // Index width for a memory of the given depth (at least one bit).
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/apb_ram_mem.sv
// DEPTH x DATA_W word array with asynchronous clear, one write port, one read port.
// Latency: write lands on the rising edge; read is combinational from the array.
// Backpressure: none; a write is accepted on every edge where wr_en is high.
//
// Ports: clk, rst_n (async active-low clear of every word),
//        wr_en/wr_addr/wr_dat (write port), rd_addr -> rd_dat (read port).
module apb_ram_mem
    import apb_ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int IDX_W  = idx_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_dat
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/apb_ram.sv
// APB3 slave wrapping a word-addressed RAM; out-of-range addresses answer pslverr.
// Latency: one wait state; pready rises on the edge ending the first access cycle.
// Backpressure: pready is held low in the access cycle, high for exactly one cycle.
//
// Ports: presetn (async active-low), pclk, APB3 request (psel, penable, pwrite,
//        paddr = word address, pwdata), registered response (prdata, pready, pslverr).
module apb_ram
    import apb_ram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              presetn,
    input  logic              pclk,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr
);

    localparam int IDX_W = idx_w(DEPTH);

    logic [DATA_W-1:0] prdata_q,  prdata_d;
    logic              pready_q,  pready_d;
    logic              pslverr_q, pslverr_d;

    logic              access;
    logic              addr_ok;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rd_dat;

    // An access is acted on once: the edge after it has been acknowledged
    // sees pready_q=1 and does nothing, so a held psel/penable simply
    // starts a fresh access on the following edge.
    assign access  = psel && penable && !pready_q;
    // Full-width compare: high address bits never alias onto low words.
    assign addr_ok = (paddr < ADDR_W'(DEPTH));
    assign idx     = paddr[IDX_W-1:0];

    apb_ram_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clk     (pclk),
        .rst_n   (presetn),
        .wr_en   (access && pwrite && addr_ok),
        .wr_addr (idx),
        .wr_dat  (pwdata),
        .rd_addr (idx),
        .rd_dat  (rd_dat)
    );

    always_comb begin
        pready_d  = access;
        pslverr_d = access && !addr_ok;
        prdata_d  = prdata_q;
        if (access && !pwrite) begin
            prdata_d = addr_ok ? rd_dat : '0;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_ram.sv
// Self-checking bench for apb_ram against a word-array reference model.
// Latency: expects pready one edge after the access phase begins.
// Backpressure: master waits (bounded) for pready before sampling.
module tb_apb_ram;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;

    logic              presetn;
    logic              pclk;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    apb_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .presetn (presetn),
        .pclk    (pclk),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int total = 0;
    int bad   = 0;

    // Reference model: plain array of words, addresses >= DEPTH are errors.
    logic [DATA_W-1:0] ref_mem [DEPTH];

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    endtask

    // Results of the last transfer.
    logic [DATA_W-1:0] x_rd;
    logic              x_err;
    int                x_lat;
    logic              x_wait_rdy;
    logic              x_after_rdy;

    // Drive one APB transfer starting just after a rising edge.
    task automatic xfer(input logic wr, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wd, input bit go_idle);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wd;
        @(posedge pclk); #1;
        penable    = 1'b1;
        x_wait_rdy = pready;
        x_lat      = 0;
        do begin
            @(posedge pclk); #1;
            x_lat++;
        end while (pready !== 1'b1 && x_lat < 8);
        x_rd  = prdata;
        x_err = pslverr;
        @(posedge pclk); #1;
        x_after_rdy = pready;
        if (go_idle) begin
            psel    = 1'b0;
            penable = 1'b0;
        end
    endtask

    task automatic test_reset();
        presetn = 1'b0;
        psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
        repeat (3) @(posedge pclk);
        #1;
        total++;
        if (prdata !== '0 || pready !== 1'b0 || pslverr !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: prdata=%h pready=%b pslverr=%b required 0/0/0",
                     prdata, pready, pslverr);
        end
        presetn = 1'b1;
        model_clear();
        @(posedge pclk); #1;
        xfer(1'b0, 32'd5, '0, 1'b1);
        total++;
        if (x_rd !== 32'h0 || x_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_read5: prdata=%h err=%b required 0/0", x_rd, x_err);
        end
    endtask

    task automatic test_basic();
        xfer(1'b1, 32'd3, 32'hDEADBEEF, 1'b1);
        ref_mem[3] = 32'hDEADBEEF;
        total++;
        if (x_wait_rdy !== 1'b0 || x_lat != 1 || x_after_rdy !== 1'b0 || x_err !== 1'b0) begin
            bad++;
            $display("FAIL write_timing: wait_rdy=%b lat=%0d after=%b err=%b required 0/1/0/0",
                     x_wait_rdy, x_lat, x_after_rdy, x_err);
        end
        @(posedge pclk); #1;
        xfer(1'b0, 32'd3, '0, 1'b1);
        total++;
        if (x_rd !== 32'hDEADBEEF || x_err !== 1'b0 || x_lat != 1 || x_after_rdy !== 1'b0) begin
            bad++;
            $display("FAIL read3: prdata=%h err=%b lat=%0d after=%b required deadbeef/0/1/0",
                     x_rd, x_err, x_lat, x_after_rdy);
        end
    endtask

    task automatic test_edges();
        xfer(1'b1, 32'd31, 32'h1, 1'b1);
        xfer(1'b1, 32'd0, 32'hFFFFFFFF, 1'b1);
        ref_mem[31] = 32'h1;
        ref_mem[0]  = 32'hFFFFFFFF;
        xfer(1'b0, 32'd31, '0, 1'b1);
        total++;
        if (x_rd !== 32'h1 || x_err !== 1'b0) begin
            bad++;
            $display("FAIL read31: prdata=%h err=%b required 00000001/0", x_rd, x_err);
        end
        xfer(1'b0, 32'd0, '0, 1'b1);
        total++;
        if (x_rd !== 32'hFFFFFFFF || x_err !== 1'b0) begin
            bad++;
            $display("FAIL read0: prdata=%h err=%b required ffffffff/0", x_rd, x_err);
        end
        xfer(1'b0, 32'd1, '0, 1'b1);
        total++;
        if (x_rd !== 32'h0 || x_err !== 1'b0) begin
            bad++;
            $display("FAIL read1: prdata=%h err=%b required 0/0", x_rd, x_err);
        end
    endtask

    task automatic test_out_of_range();
        xfer(1'b1, 32'd32, 32'h55, 1'b1);
        total++;
        if (x_err !== 1'b1 || x_lat != 1) begin
            bad++;
            $display("FAIL write32_err: err=%b lat=%0d required 1/1", x_err, x_lat);
        end
        xfer(1'b0, 32'd0, '0, 1'b1);
        total++;
        if (x_rd !== ref_mem[0] || x_err !== 1'b0) begin
            bad++;
            $display("FAIL read0_after_bad: prdata=%h err=%b required %h/0", x_rd, x_err, ref_mem[0]);
        end
        xfer(1'b0, 32'd32, '0, 1'b1);
        total++;
        if (x_rd !== 32'h0 || x_err !== 1'b1) begin
            bad++;
            $display("FAIL read32: prdata=%h err=%b required 0/1", x_rd, x_err);
        end
        // High address bit set: must not alias onto word 0.
        xfer(1'b1, 32'h8000_0000, 32'h1234, 1'b1);
        xfer(1'b0, 32'd0, '0, 1'b1);
        total++;
        if (x_rd !== ref_mem[0] || x_err !== 1'b0) begin
            bad++;
            $display("FAIL no_alias: prdata=%h err=%b required %h/0", x_rd, x_err, ref_mem[0]);
        end
    endtask

    task automatic test_back_to_back();
        xfer(1'b1, 32'd7, 32'hA5A5A5A5, 1'b0);
        ref_mem[7] = 32'hA5A5A5A5;
        xfer(1'b0, 32'd7, '0, 1'b1);
        total++;
        if (x_rd !== 32'hA5A5A5A5 || x_err !== 1'b0 || x_lat != 1) begin
            bad++;
            $display("FAIL b2b_read7: prdata=%h err=%b lat=%0d required a5a5a5a5/0/1",
                     x_rd, x_err, x_lat);
        end
    endtask

    task automatic test_protocol();
        logic [3:0] seen;
        // penable without psel: no response, no write.
        psel = 1'b0; penable = 1'b1; pwrite = 1'b1; paddr = 32'd9; pwdata = 32'hBAD0BAD0;
        repeat (3) @(posedge pclk);
        #1;
        total++;
        if (pready !== 1'b0) begin
            bad++;
            $display("FAIL penable_no_psel: pready=%b required 0", pready);
        end
        penable = 1'b0;
        xfer(1'b0, 32'd9, '0, 1'b1);
        total++;
        if (x_rd !== ref_mem[9]) begin
            bad++;
            $display("FAIL penable_no_psel_mem: prdata=%h required %h", x_rd, ref_mem[9]);
        end
        // psel/penable held: a new access restarts every other edge.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'd3;
        @(posedge pclk); #1;
        penable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge pclk); #1;
            seen[i] = pready;
        end
        psel = 1'b0; penable = 1'b0;
        total++;
        if (seen !== 4'b0101 || prdata !== ref_mem[3]) begin
            bad++;
            $display("FAIL held_access: pready_seq=%b prdata=%h required 0101/%h",
                     seen, prdata, ref_mem[3]);
        end
        @(posedge pclk); #1;
    endtask

    task automatic test_reset_mid();
        xfer(1'b1, 32'd2, 32'h12, 1'b1);
        // Start a read of addr 2 and reset while it is being acknowledged.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'd2;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #2;
        total++;
        if (pready !== 1'b1 || prdata !== 32'h12) begin
            bad++;
            $display("FAIL pre_reset_ack: pready=%b prdata=%h required 1/00000012", pready, prdata);
        end
        presetn = 1'b0;
        psel = 1'b0; penable = 1'b0;
        #1;
        total++;
        if (prdata !== '0 || pready !== 1'b0 || pslverr !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: prdata=%h pready=%b pslverr=%b required 0/0/0",
                     prdata, pready, pslverr);
        end
        model_clear();
        @(posedge pclk); #1;
        presetn = 1'b1;
        @(posedge pclk); #1;
        xfer(1'b0, 32'd2, '0, 1'b1);
        total++;
        if (x_rd !== 32'h0 || x_err !== 1'b0) begin
            bad++;
            $display("FAIL read2_after_reset: prdata=%h err=%b required 0/0", x_rd, x_err);
        end
    endtask

    task automatic test_random();
        logic              wr;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] exp_rd;
        logic              exp_err;
        for (int n = 0; n < 30; n++) begin
            wr = 1'($urandom_range(0, 1));
            a  = ADDR_W'($urandom_range(0, 40));
            d  = $urandom;
            exp_err = (a >= DEPTH);
            exp_rd  = exp_err ? '0 : ref_mem[a[4:0]];
            xfer(wr, a, d, ($urandom_range(0, 1) == 1) || (n == 29));
            if (wr && !exp_err) ref_mem[a[4:0]] = d;
            total++;
            if (x_err !== exp_err || x_lat != 1 || (!wr && x_rd !== exp_rd)) begin
                bad++;
                $display("FAIL random[%0d]: wr=%b addr=%0d prdata=%h err=%b lat=%0d required %h/%b/1",
                         n, wr, a, x_rd, x_err, x_lat, exp_rd, exp_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edges();
        test_out_of_range();
        test_back_to_back();
        test_protocol();
        test_reset_mid();
        test_random();
        repeat (2) @(posedge pclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
